// File: rtl/core_pkg.sv
// Shared definitions for the fetch aligner: aligner state encoding and
// the RISC-V length-decode constant.
package core_pkg;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned HALF_W  = 16;

   // Low two bits of a halfword that mark a full-length (32-bit) instruction
   localparam logic [1:0] OPC_32BIT = 2'b11;

   typedef enum logic [1:0] {
      EMPTY      = 2'd0,
      ALIGNED    = 2'd1,
      MISALIGNED = 2'd2
   } align_state_e;

endpackage : core_pkg

// File: rtl/core_fetch_fifo.sv
// Fetch-word buffer: circular FIFO with occupancy count and a peek of the
// two oldest entries so the aligner can straddle a word boundary.
import core_pkg::*;

module core_fetch_fifo #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic [INSTR_W-1:0]       data_i,
   input  logic                     pop_i,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic [INSTR_W-1:0]       entry0_o,
   output logic [INSTR_W-1:0]       entry1_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [INSTR_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]      rd_q;
   logic [AW-1:0]      wr_q;
   logic [CW-1:0]      count_q;
   logic               push_ok;
   logic               pop_ok;

   // Guard against overflow/underflow regardless of what the caller asks for
   assign push_ok = push_i && !flush_i && (count_q < CW'(DEPTH));
   assign pop_ok  = pop_i && !flush_i && (count_q != '0);

   // Pointer and occupancy bookkeeping; flush empties the buffer
   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         rd_q    <= '0;
         wr_q    <= '0;
         count_q <= '0;
      end else begin
         if (push_ok) wr_q <= wr_q + AW'(1);
         if (pop_ok)  rd_q <= rd_q + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage array; contents are meaningless until counted as valid
   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_q] <= data_i;
   end

   assign count_o  = count_q;
   assign entry0_o = mem_q[rd_q];
   assign entry1_o = mem_q[rd_q + AW'(1)];

endmodule : core_fetch_fifo

// File: rtl/core_fetch_align.sv
// Instruction fetch aligner: buffers 32-bit fetch words and hands decode
// one instruction per handshake, splitting/joining halfwords for RVC.
// Optional feature macro: CORE_FETCH_RVC_EN (compressed-instruction support).
import core_pkg::*;

module core_fetch_align #(
   parameter int unsigned     XLEN       = 32,
   parameter logic [XLEN-1:0] RESET_PC   = XLEN'(32'h1000_0000),
   parameter int unsigned     FIFO_DEPTH = 4
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               flush_i,
   input  logic [XLEN-1:0]    flush_pc_i,
   input  logic               fetch_valid_i,
   input  logic [31:0]        fetch_data_i,
   output logic               fetch_ready_o,
   output logic               instr_valid_o,
   output logic [31:0]        instr_o,
   output logic [XLEN-1:0]    instr_pc_o,
   output logic               instr_compressed_o,
   input  logic               instr_ready_i
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   align_state_e     state_q, state_d;
   logic [XLEN-1:0]  pc_q, pc_d;
   logic             off_q, off_d;
   logic [CW-1:0]    count, count_d;
   logic [31:0]      head, entry1;
   logic             push, pop, fire;
   logic             is_c, h1_ok, next_off, flush_off;
   logic [XLEN-1:0]  flush_pc_eff;

`ifdef CORE_FETCH_RVC_EN
   localparam logic [XLEN-1:0] RESET_PC_EFF = RESET_PC & ~XLEN'(1);
   localparam logic            RESET_OFF    = RESET_PC[1];

   logic [HALF_W-1:0] h0, h1;
   logic              unused_rvc;

   // Halfword select: current halfword and its successor, possibly in entry1
   assign h0           = off_q ? head[31:16]   : head[15:0];
   assign h1           = off_q ? entry1[15:0]  : head[31:16];
   assign is_c         = (h0[1:0] != OPC_32BIT);
   assign h1_ok        = is_c || !off_q || (count >= CW'(2));
   assign instr_o      = is_c ? {16'h0000, h0} : {h1, h0};
   // Head word is retired once the consumed instruction ends in its top half
   assign pop          = fire && (off_q || !is_c);
   assign next_off     = off_q ^ is_c;
   assign flush_pc_eff = {flush_pc_i[XLEN-1:1], 1'b0};
   assign flush_off    = flush_pc_i[1];
   assign unused_rvc   = flush_pc_i[0];
`else
   localparam logic [XLEN-1:0] RESET_PC_EFF = RESET_PC & ~XLEN'(3);
   localparam logic            RESET_OFF    = 1'b0;

   logic unused_nonrvc;

   // Word-aligned only: one fetch word is exactly one instruction
   assign is_c          = 1'b0;
   assign h1_ok         = 1'b1;
   assign instr_o       = head;
   assign pop           = fire;
   assign next_off      = 1'b0;
   assign flush_pc_eff  = {flush_pc_i[XLEN-1:2], 2'b00};
   assign flush_off     = 1'b0;
   assign unused_nonrvc = ^{entry1, flush_pc_i[1:0]};
`endif

   core_fetch_fifo #(
      .DEPTH    (FIFO_DEPTH)
   ) u_fifo (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .flush_i  (flush_i),
      .push_i   (push),
      .data_i   (fetch_data_i),
      .pop_i    (pop),
      .count_o  (count),
      .entry0_o (head),
      .entry1_o (entry1)
   );

   // Handshake qualifiers; no same-cycle bypass when the buffer is full
   assign fetch_ready_o      = !rst_i && !flush_i && (count < CW'(FIFO_DEPTH));
   assign push               = fetch_valid_i && fetch_ready_o;
   assign instr_valid_o      = (state_q != EMPTY) && h1_ok;
   assign fire               = instr_valid_o && instr_ready_i && !flush_i;
   assign instr_pc_o         = pc_q;
   assign instr_compressed_o = is_c;

   // Aligner state register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= EMPTY;
         pc_q    <= RESET_PC_EFF;
         off_q   <= RESET_OFF;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         off_q   <= off_d;
      end
   end

   // Next-state: flush beats handshake; state mirrors next occupancy/offset
   always_comb begin
      count_d = count;
      pc_d    = pc_q;
      off_d   = off_q;
      case ({push, pop})
         2'b10:   count_d = count + CW'(1);
         2'b01:   count_d = count - CW'(1);
         default: count_d = count;
      endcase
      if (flush_i) begin
         count_d = '0;
         pc_d    = flush_pc_eff;
         off_d   = flush_off;
      end else if (fire) begin
         pc_d    = pc_q + XLEN'(is_c ? 2 : 4);
         off_d   = next_off;
      end
      if (count_d == '0)  state_d = EMPTY;
      else if (off_d)     state_d = MISALIGNED;
      else                state_d = ALIGNED;
   end

endmodule : core_fetch_align

// File: tb/tb_core_fetch_align.sv
// Directed bench for core_fetch_align (default and CORE_FETCH_RVC_EN builds).
module tb_core_fetch_align;

   localparam logic [31:0] RST_PC = 32'h1000_0000;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        flush_i;
   logic [31:0] flush_pc_i;
   logic        fetch_valid_i;
   logic [31:0] fetch_data_i;
   logic        fetch_ready_o;
   logic        instr_valid_o;
   logic [31:0] instr_o;
   logic [31:0] instr_pc_o;
   logic        instr_compressed_o;
   logic        instr_ready_i;

   int errors = 0;
   int checks = 0;

   always #5 clk_i = ~clk_i;

   core_fetch_align dut (
      .clk_i              (clk_i),
      .rst_i              (rst_i),
      .flush_i            (flush_i),
      .flush_pc_i         (flush_pc_i),
      .fetch_valid_i      (fetch_valid_i),
      .fetch_data_i       (fetch_data_i),
      .fetch_ready_o      (fetch_ready_o),
      .instr_valid_o      (instr_valid_o),
      .instr_o            (instr_o),
      .instr_pc_o         (instr_pc_o),
      .instr_compressed_o (instr_compressed_o),
      .instr_ready_i      (instr_ready_i)
   );

   typedef struct packed {
      logic        rst;
      logic        push;
      logic [31:0] data;
      logic        rdy;
      logic        ev;
      logic [31:0] ei;
      logic [31:0] ep;
      logic        ec;
      logic        ef;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      rst_i = 1'b1; flush_i = 1'b0; flush_pc_i = '0;
      fetch_valid_i = 1'b0; fetch_data_i = '0; instr_ready_i = 1'b0;
      step();
      #2;
      chk("reset_valid", 32'(instr_valid_o), 32'd0);
      chk("reset_fready", 32'(fetch_ready_o), 32'd0);
      step();
      rst_i = 1'b0;
   endtask

   task automatic check_instr(input string tag, input logic [31:0] ei,
                              input logic [31:0] ep, input logic ec);
      chk({tag, "_valid"}, 32'(instr_valid_o), 32'd1);
      chk({tag, "_instr"}, instr_o, ei);
      chk({tag, "_pc"}, instr_pc_o, ep);
      chk({tag, "_comp"}, 32'(instr_compressed_o), 32'(ec));
   endtask

   vec_t        vecs [9];
   int          nv;
   logic [31:0] words [6];
   int          idx, got, acc_hold;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();

      // ---------------- table-driven vectors ----------------
`ifdef CORE_FETCH_RVC_EN
      nv = 9;
      vecs[0] = '{1'b0, 1'b1, 32'h0513_4501, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1};
      vecs[1] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_4501, 32'h1000_0000, 1'b1, 1'b1};
      vecs[2] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1};
      vecs[3] = '{1'b0, 1'b1, 32'h0000_00A0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1};
      vecs[4] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h00A0_0513, 32'h1000_0002, 1'b0, 1'b1};
      vecs[5] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0000, 32'h1000_0006, 1'b1, 1'b1};
      vecs[6] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0};
      vecs[7] = '{1'b0, 1'b1, 32'h00A0_0513, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1};
      vecs[8] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h00A0_0513, 32'h1000_0000, 1'b0, 1'b1};
`else
      nv = 6;
      vecs[0] = '{1'b0, 1'b1, 32'h00A0_0513, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1};
      vecs[1] = '{1'b0, 1'b1, 32'h0015_0593, 1'b1, 1'b1, 32'h00A0_0513, 32'h1000_0000, 1'b0, 1'b1};
      vecs[2] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0015_0593, 32'h1000_0004, 1'b0, 1'b1};
      vecs[3] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0};
      vecs[4] = '{1'b0, 1'b1, 32'h0000_4501, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1};
      vecs[5] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_4501, 32'h1000_0000, 1'b0, 1'b1};
`endif
      for (int i = 0; i < nv; i++) begin
         rst_i         = vecs[i].rst;
         fetch_valid_i = vecs[i].push;
         fetch_data_i  = vecs[i].data;
         instr_ready_i = vecs[i].rdy;
         flush_i       = 1'b0;
         #2;
         chk($sformatf("vec%0d_fready", i), 32'(fetch_ready_o), 32'(vecs[i].ef));
         chk($sformatf("vec%0d_valid", i), 32'(instr_valid_o), 32'(vecs[i].ev));
         if (vecs[i].ev) begin
            chk($sformatf("vec%0d_instr", i), instr_o, vecs[i].ei);
            chk($sformatf("vec%0d_pc", i), instr_pc_o, vecs[i].ep);
            chk($sformatf("vec%0d_comp", i), 32'(instr_compressed_o), 32'(vecs[i].ec));
         end
         step();
      end
      rst_i = 1'b0; fetch_valid_i = 1'b0;

      // ---------------- backpressure: decode stalls 6 cycles ----------------
      do_reset();
      for (int k = 0; k < 6; k++) words[k] = 32'h1000_0013 + 32'(k) * 32'h100;
      idx = 0; got = 0; acc_hold = 0;
      for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
         instr_ready_i = (cyc >= 6);
         fetch_valid_i = (idx < 6);
         fetch_data_i  = (idx < 6) ? words[idx] : 32'h0;
         #2;
         if (cyc < 6 && fetch_valid_i && fetch_ready_o) acc_hold++;
         if (cyc >= 1 && cyc < 6) check_instr($sformatf("hold%0d", cyc), words[0], RST_PC, 1'b0);
         if (fetch_valid_i && fetch_ready_o) idx++;
         if (instr_valid_o && instr_ready_i) begin
            chk($sformatf("drain%0d_instr", got), instr_o, words[got]);
            chk($sformatf("drain%0d_pc", got), instr_pc_o, RST_PC + 32'(got) * 32'd4);
            got++;
         end
         step();
      end
      chk("hold_accepts", 32'(acc_hold), 32'd4);
      chk("drain_count", 32'(got), 32'd6);
      fetch_valid_i = 1'b0; instr_ready_i = 1'b0;

      // ---------------- flush while full with a simultaneous push ----------------
      do_reset();
      for (int k = 0; k < 4; k++) begin
         fetch_valid_i = 1'b1;
         fetch_data_i  = 32'h2000_0013 + 32'(k);
         step();
      end
      flush_i = 1'b1; flush_pc_i = 32'h1000_0102;
      fetch_valid_i = 1'b1; fetch_data_i = 32'hDEAD_BEEF;
      #2;
      chk("flush_fready", 32'(fetch_ready_o), 32'd0);
      step();
      flush_i = 1'b0; fetch_valid_i = 1'b0;
      #2;
      chk("postflush_valid", 32'(instr_valid_o), 32'd0);
      chk("postflush_fready", 32'(fetch_ready_o), 32'd1);
      fetch_valid_i = 1'b1; fetch_data_i = 32'h4505_0013; instr_ready_i = 1'b1;
      step();
      fetch_valid_i = 1'b0;
      #2;
`ifdef CORE_FETCH_RVC_EN
      check_instr("flush_first", 32'h0000_4505, 32'h1000_0102, 1'b1);
`else
      check_instr("flush_first", 32'h4505_0013, 32'h1000_0100, 1'b0);
`endif
      step();
      instr_ready_i = 1'b0;

      // ---------------- reset mid-stream, overriding a flush ----------------
      do_reset();
      for (int k = 0; k < 3; k++) begin
         fetch_valid_i = 1'b1;
         fetch_data_i  = 32'h3000_0013 + 32'(k);
         step();
      end
      rst_i = 1'b1; flush_i = 1'b1; flush_pc_i = 32'h2000_0000;
      fetch_valid_i = 1'b0; instr_ready_i = 1'b1;
      #2;
      chk("midrst_fready", 32'(fetch_ready_o), 32'd0);
      step();
      rst_i = 1'b0; flush_i = 1'b0;
      #2;
      chk("midrst_valid", 32'(instr_valid_o), 32'd0);
      chk("midrst_fready_after", 32'(fetch_ready_o), 32'd1);
      fetch_valid_i = 1'b1; fetch_data_i = 32'h0000_0593;
      step();
      fetch_valid_i = 1'b0;
      #2;
      check_instr("midrst_first", 32'h0000_0593, RST_PC, 1'b0);
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_core_fetch_align
